// File: rtl/arb_req_pkg.sv
// arb_req_pkg: shared state encoding and default widths for the arbiter requester endpoint
package arb_req_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    localparam int LEN_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/arbiter_requester_wait_watchdog.sv
// wait_watchdog: saturating count of consecutive ungranted request cycles plus starvation flag
module wait_watchdog
    import arb_req_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int STARVE_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             gnt,
    output logic             starved,
    output logic [CNT_W-1:0] wait_cycles
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic waiting;

    assign waiting = req && !gnt;
    assign starved = wait_cycles >= CNT_W'(STARVE_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wait_cycles <= '0;
        else
            wait_cycles <= !waiting ? '0 : (wait_cycles == MAX ? MAX : wait_cycles + CNT_W'(1));
    end

endmodule

// File: rtl/arbiter_requester.sv
// arbiter_requester: requester-side endpoint issuing burst requests to one round-robin arbiter port
module arbiter_requester
    import arb_req_pkg::*;
#(
    parameter int LEN_W        = LEN_W_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int STARVE_LIMIT = 16,
    parameter int RELEASE      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [LEN_W-1:0] job_len,
    output logic             req,
    input  logic             gnt,
    output logic             beat,
    output logic             last,
    output logic             busy,
    output logic             starved,
    output logic [CNT_W-1:0] wait_cycles,
    output logic             gnt_err
);

    state_t           state, state_n;
    logic [LEN_W-1:0] remaining, remaining_n;

    assign beat      = req && gnt;
    assign last      = beat && remaining == '0;
    assign busy      = state != IDLE;
    assign job_ready = state == IDLE || (RELEASE == 0 && last);

    // job_ready already folds in state, so job_valid alone marks an accept in the branches below
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        case (state)
            IDLE: begin
                if (job_valid) begin
                    state_n     = ACTIVE;
                    remaining_n = job_len;
                end
            end
            ACTIVE: begin
                if (last) begin
                    if (RELEASE != 0)
                        state_n = GAP;
                    else if (job_valid)
                        remaining_n = job_len;
                    else
                        state_n = IDLE;
                end else if (beat) begin
                    remaining_n = remaining - LEN_W'(1);
                end
            end
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            req       <= 1'b0;
            gnt_err   <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            req       <= state_n == ACTIVE;
            gnt_err   <= gnt_err || (gnt && !req);
        end
    end

    wait_watchdog #(
        .CNT_W       (CNT_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .starved    (starved),
        .wait_cycles(wait_cycles)
    );

endmodule

// File: tb/tb_arbiter_requester.sv
// tb_arbiter_requester: two endpoints (release/no-release) driven randomly and by a round-robin arbiter, checked against a beat-count model
module tb_arbiter_requester;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] job_valid = '0;
    logic [1:0] gnt = '0;
    logic [3:0] len0 = '0, len1 = '0;
    logic [1:0] job_ready, req, beat, last, busy, starved, gnt_err;
    logic [7:0] wc0;
    logic [3:0] wc1;

    int vectors = 0, miscompares = 0;
    int rel[2]  = '{1, 0};
    int lim[2]  = '{16, 5};
    int cmax[2] = '{255, 15};
    bit m_act[2], m_gap[2], m_err[2];
    int m_left[2], m_wait[2];
    int rr_last = 0;

    always #5 clk = ~clk;

    arbiter_requester #(.LEN_W(4), .CNT_W(8), .STARVE_LIMIT(16), .RELEASE(1)) u0 (
        .clk(clk), .rst(rst), .job_valid(job_valid[0]), .job_ready(job_ready[0]), .job_len(len0),
        .req(req[0]), .gnt(gnt[0]), .beat(beat[0]), .last(last[0]), .busy(busy[0]),
        .starved(starved[0]), .wait_cycles(wc0), .gnt_err(gnt_err[0]));

    arbiter_requester #(.LEN_W(4), .CNT_W(4), .STARVE_LIMIT(5), .RELEASE(0)) u1 (
        .clk(clk), .rst(rst), .job_valid(job_valid[1]), .job_ready(job_ready[1]), .job_len(len1),
        .req(req[1]), .gnt(gnt[1]), .beat(beat[1]), .last(last[1]), .busy(busy[1]),
        .starved(starved[1]), .wait_cycles(wc1), .gnt_err(gnt_err[1]));

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] observed(int i);
        logic [7:0] w = (i == 0) ? wc0 : {4'b0, wc1};
        return {req[i], beat[i], last[i], busy[i], starved[i], job_ready[i], gnt_err[i], 1'b0, w};
    endfunction

    // model tracks beats still owed (not beats-1), so last is "one beat left"
    function automatic logic [15:0] expected(int i);
        bit r  = m_act[i];
        bit b  = r && gnt[i];
        bit l  = b && m_left[i] == 1;
        bit rd = (!m_act[i] && !m_gap[i]) || (rel[i] == 0 && l);
        bit st = m_wait[i] >= lim[i];
        return {r, b, l, m_act[i] || m_gap[i], st, rd, m_err[i], 1'b0, 8'(m_wait[i])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_gap[i] = 0; m_err[i] = 0; m_left[i] = 0; m_wait[i] = 0;
        end
    endtask

    task automatic step(int i);
        bit r    = m_act[i];
        bit g    = gnt[i];
        bit b    = r && g;
        bit l    = b && m_left[i] == 1;
        bit idle = !m_act[i] && !m_gap[i];
        bit acc  = job_valid[i] && (idle || (rel[i] == 0 && l));
        int n    = int'(i == 0 ? len0 : len1) + 1;
        if (g && !r) m_err[i] = 1;
        m_wait[i] = (r && !g) ? ((m_wait[i] < cmax[i]) ? m_wait[i] + 1 : m_wait[i]) : 0;
        if (idle) begin
            if (acc) begin m_act[i] = 1; m_left[i] = n; end
        end else if (m_gap[i]) begin
            m_gap[i] = 0;
        end else if (b) begin
            if (!l) m_left[i]--;
            else if (rel[i] != 0) begin m_act[i] = 0; m_gap[i] = 1; end
            else if (acc) m_left[i] = n;
            else m_act[i] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        job_valid = '0; gnt = '0; rst = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) check_eq($sformatf("reset_u%0d", i), observed(i), expected(i));
    endtask

    // mode: 0 random, 1 sparse grants, 2 round-robin arbiter, 3 grant stuck high, 4 no grants, 5 held valid short bursts
    task automatic cycle(int mode, bit allow_rst);
        int pick;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            logic [3:0] l = (mode == 2) ? 4'd0 : (mode == 5) ? 4'($urandom_range(1)) : 4'($urandom_range(15));
            job_valid[i] = (mode == 2 || mode == 4 || mode == 5) ? 1'b1 : ($urandom_range(3) != 0);
            if (i == 0) len0 = l; else len1 = l;
            gnt[i] = (mode == 0) ? 1'($urandom_range(1)) : (mode == 1) ? ($urandom_range(39) == 0) :
                     (mode == 3) ? 1'b1 : (mode == 5) ? ($urandom_range(3) != 0) : 1'b0;
        end
        if (mode == 2) begin
            pick = (m_act[0] && m_act[1]) ? 1 - rr_last : m_act[0] ? 0 : m_act[1] ? 1 : -1;
            if (pick >= 0) begin gnt[pick] = 1'b1; rr_last = pick; end
        end
        #1;
        for (int i = 0; i < 2; i++) check_eq($sformatf("m%0d_u%0d", mode, i), observed(i), expected(i));
        if (allow_rst && $urandom_range(119) == 0) begin
            #2 rst = 1'b0;
            model_reset();
            #1;
            for (int i = 0; i < 2; i++) check_eq($sformatf("async_rst_u%0d", i), observed(i), expected(i));
        end else begin
            for (int i = 0; i < 2; i++) step(i);
        end
    endtask

    initial begin
        model_reset();
        do_reset();
        repeat (400) cycle(0, 1);
        repeat (300) cycle(4, 0);
        repeat (200) cycle(1, 1);
        repeat (100) cycle(3, 1);
        repeat (60)  cycle(5, 0);
        do_reset();
        repeat (200) cycle(2, 0);
        repeat (4)   cycle(3, 0);
        do_reset();
        repeat (20)  cycle(0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
